// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - memory-stage opcodes and opcode decode helpers
//
// Purpose: opcode encodings for the aluop bus driven by execute, plus small
//          decode helpers shared by mem_stage and mem_load_ext.
// Contents: aluop_t, MEM_* opcodes, is_load_op, is_store_op, op_bytes.
package mem_stage_pkg;

    localparam int ALU_OP_W = 8;

    typedef logic [ALU_OP_W-1:0] aluop_t;

    localparam aluop_t MEM_NOP = 8'h00;
    localparam aluop_t MEM_LB  = 8'h20;
    localparam aluop_t MEM_LH  = 8'h21;
    localparam aluop_t MEM_LW  = 8'h22;
    localparam aluop_t MEM_LBU = 8'h23;
    localparam aluop_t MEM_LHU = 8'h24;
    localparam aluop_t MEM_SB  = 8'h28;
    localparam aluop_t MEM_SH  = 8'h29;
    localparam aluop_t MEM_SW  = 8'h2A;

    function automatic logic is_load_op(input aluop_t op);
        return (op == MEM_LB) || (op == MEM_LH) || (op == MEM_LW) ||
               (op == MEM_LBU) || (op == MEM_LHU);
    endfunction

    function automatic logic is_store_op(input aluop_t op);
        return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
    endfunction

    // Number of bytes moved by the op; zero for anything that is not a memory op.
    function automatic logic [2:0] op_bytes(input aluop_t op);
        case (op)
            MEM_LB, MEM_LBU, MEM_SB: op_bytes = 3'd1;
            MEM_LH, MEM_LHU, MEM_SH: op_bytes = 3'd2;
            MEM_LW, MEM_SW:          op_bytes = 3'd4;
            default:                 op_bytes = 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/mem_load_ext.sv
// rtl/mem_load_ext.sv - load result sign/zero extension
//
// Purpose: turns the four assembled little-endian load bytes into the
//          register write value according to the load opcode.
// Ports:   op_i    - load opcode
//          bytes_i - assembled bytes, byte k in bits [8k+7:8k]
//          data_o  - extended result
module mem_load_ext
    import mem_stage_pkg::*;
(
    input  aluop_t      op_i,
    input  logic [31:0] bytes_i,
    output logic [31:0] data_o
);

    always_comb begin
        data_o = bytes_i;
        case (op_i)
            MEM_LB:  data_o = {{24{bytes_i[7]}}, bytes_i[7:0]};
            MEM_LBU: data_o = {24'h000000, bytes_i[7:0]};
            MEM_LH:  data_o = {{16{bytes_i[15]}}, bytes_i[15:0]};
            MEM_LHU: data_o = {16'h0000, bytes_i[15:0]};
            default: data_o = bytes_i;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory-access pipeline stage over a byte-wide arbitrated port
//
// Purpose: executes loads/stores one byte per granted cycle, stalling the
//          pipeline until done; non-memory ops pass straight through.
// Ports:   clk, rst (sync, active-high), rdy (global enable)
//          aluop_i/addr_i/wd_i/wreg_i/wdata_i - from EX/MEM, held while stalled
//          wd_o/wreg_o/wdata_o                - to MEM/WB
//          stall_req                          - freeze upstream, bubble MEM/WB
//          mem_req_o/mem_we_o/mem_addr_o/mem_dout_o/mem_din_i/mem_gnt_i - byte port
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int READ_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  aluop_t      aluop_i,
    input  logic [31:0] addr_i,
    input  logic [4:0]  wd_i,
    input  logic        wreg_i,
    input  logic [31:0] wdata_i,
    output logic [4:0]  wd_o,
    output logic        wreg_o,
    output logic [31:0] wdata_o,
    output logic        stall_req,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [7:0]  mem_dout_o,
    input  logic [7:0]  mem_din_i,
    input  logic        mem_gnt_i
);

    typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_DONE} state_t;

    state_t              state_q, state_d;
    logic [2:0]          issue_cnt_q, issue_cnt_d;
    logic [2:0]          recv_cnt_q, recv_cnt_d;
    logic [READ_LAT-1:0] rd_vld_q, rd_vld_d;
    logic [31:0]         rbytes_q, rbytes_d;

    logic        is_load, is_store, active, granted, emerge;
    logic [2:0]  nbytes;
    logic [31:0] load_data;

    assign is_load  = is_load_op(aluop_i);
    assign is_store = is_store_op(aluop_i);
    assign nbytes   = op_bytes(aluop_i);

    // IDLE with a memory op behaves exactly like ACCESS with zero counts,
    // which is what gives the request in cycle 0.
    assign active  = (state_q == ST_ACCESS) || ((state_q == ST_IDLE) && (is_load || is_store));
    assign granted = mem_req_o & mem_gnt_i;
    assign emerge  = rd_vld_q[READ_LAT-1];

    mem_load_ext u_load_ext (
        .op_i    (aluop_i),
        .bytes_i (rbytes_q),
        .data_o  (load_data)
    );

    always_comb begin
        wd_o       = wd_i;
        wreg_o     = wreg_i;
        wdata_o    = wdata_i;
        stall_req  = 1'b0;
        mem_req_o  = !rst && rdy && active && (issue_cnt_q < nbytes);
        mem_we_o   = mem_req_o && is_store;
        mem_addr_o = addr_i + {29'd0, issue_cnt_q};
        mem_dout_o = wdata_i[{issue_cnt_q[1:0], 3'b000} +: 8];
        if (rst) begin
            wd_o    = 5'd0;
            wreg_o  = 1'b0;
            wdata_o = 32'd0;
        end else if (active) begin
            stall_req = 1'b1;
            wreg_o    = 1'b0;
            wdata_o   = 32'd0;
        end else if (state_q == ST_DONE) begin
            wreg_o  = is_load ? wreg_i : 1'b0;
            wdata_o = is_load ? load_data : 32'd0;
        end
    end

    always_comb begin
        state_d     = state_q;
        issue_cnt_d = issue_cnt_q;
        recv_cnt_d  = recv_cnt_q;
        rd_vld_d    = rd_vld_q;
        rbytes_d    = rbytes_q;
        if (rdy) begin
            case (state_q)
                ST_IDLE, ST_ACCESS: begin
                    if (active) begin
                        // Valid bits follow granted read bytes until their data is on mem_din_i.
                        rd_vld_d[0] = granted & is_load;
                        for (int i = 1; i < READ_LAT; i++) begin
                            rd_vld_d[i] = rd_vld_q[i-1];
                        end
                        if (granted) begin
                            issue_cnt_d = issue_cnt_q + 3'd1;
                        end
                        if (emerge) begin
                            rbytes_d[{recv_cnt_q[1:0], 3'b000} +: 8] = mem_din_i;
                            recv_cnt_d = recv_cnt_q + 3'd1;
                        end
                        if ((is_store && granted && (issue_cnt_q == nbytes - 3'd1)) ||
                            (is_load && emerge && (recv_cnt_q == nbytes - 3'd1))) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_ACCESS;
                        end
                    end
                end
                ST_DONE: begin
                    // EX/MEM advances on this edge, so the next op starts from clean counters.
                    state_d     = ST_IDLE;
                    issue_cnt_d = 3'd0;
                    recv_cnt_d  = 3'd0;
                    rd_vld_d    = '0;
                    rbytes_d    = 32'd0;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            issue_cnt_q <= 3'd0;
            recv_cnt_q  <= 3'd0;
            rd_vld_q    <= '0;
            rbytes_q    <= 32'd0;
        end else begin
            state_q     <= state_d;
            issue_cnt_q <= issue_cnt_d;
            recv_cnt_q  <= recv_cnt_d;
            rd_vld_q    <= rd_vld_d;
            rbytes_q    <= rbytes_d;
        end
    end

endmodule
